alu_writeback: RTL and testbench

//  Execute->writeback stage downstream of the ALU. Accepts one ALU result (d) plus new flags (ps_out) per transaction.

---
 rtl/alu_writeback.sv | 206 ++++++++++++++++++++
 tb/tb_alu_writeback.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// Execute->writeback stage: commits one ALU result per transaction to the register file or the
// memory bus, owns the architectural PS register and reports write-back faults.
module alu_writeback #(
    parameter int unsigned TIMEOUT = 64,
    parameter logic [7:0]  PS_INIT = 8'hE0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_d,
    input  logic [7:0]  in_ps,
    input  logic        in_ps_we,
    input  logic [1:0]  in_dest,
    input  logic [2:0]  in_reg,
    input  logic [15:0] in_addr,
    input  logic        in_byte,
    input  logic        in_sxt,

    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic        rf_wbyte,

    output logic        bus_req,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    output logic [1:0]  bus_sel,
    input  logic        bus_ack,
    input  logic        bus_err,

    input  logic        ps_ld,
    input  logic [7:0]  ps_ld_val,
    output logic [7:0]  ps,

    output logic        wb_err,
    output logic [1:0]  wb_err_code
);

    localparam int unsigned    CntW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    localparam logic [1:0] DestReg = 2'd1;
    localparam logic [1:0] DestMem = 2'd2;

    localparam logic [1:0] CodeOdd     = 2'd0;
    localparam logic [1:0] CodeBusErr  = 2'd1;
    localparam logic [1:0] CodeTimeout = 2'd2;

    typedef enum logic [1:0] {StIdle, StCommit, StBus, StFault} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      code_q, code_d;
    logic [7:0]      ps_q, ps_d;
    logic            commit;
    logic            accept;

    logic [15:0]     d_q;
    logic [7:0]      ps_new_q;
    logic            ps_we_q;
    logic [1:0]      dest_q;
    logic [2:0]      reg_q;
    logic [15:0]     addr_q;
    logic            byte_q;
    logic            sxt_q;

    assign in_ready = (state_q == StIdle);
    assign accept   = in_valid & in_ready;

    // Transaction fields are captured once at accept and held for the rest of the transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q      <= '0;
            ps_new_q <= '0;
            ps_we_q  <= 1'b0;
            dest_q   <= '0;
            reg_q    <= '0;
            addr_q   <= '0;
            byte_q   <= 1'b0;
            sxt_q    <= 1'b0;
        end else if (accept) begin
            d_q      <= in_d;
            ps_new_q <= in_ps;
            ps_we_q  <= in_ps_we;
            dest_q   <= in_dest;
            reg_q    <= in_reg;
            addr_q   <= in_addr;
            byte_q   <= in_byte;
            sxt_q    <= in_sxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            code_q  <= CodeOdd;
            ps_q    <= PS_INIT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            ps_q    <= ps_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (accept) begin
                    if (in_dest == DestMem) begin
                        // Misaligned word stores fault before any bus cycle starts.
                        if (!in_byte && in_addr[0]) begin
                            state_d = StFault;
                            code_d  = CodeOdd;
                        end else begin
                            state_d = StBus;
                        end
                    end else begin
                        state_d = StCommit;
                    end
                end
            end
            StCommit: begin
                commit  = 1'b1;
                state_d = StIdle;
            end
            StBus: begin
                if (bus_err) begin
                    state_d = StFault;
                    code_d  = CodeBusErr;
                end else if (bus_ack) begin
                    commit  = 1'b1;
                    state_d = StIdle;
                end else if (cnt_q == CntMax) begin
                    state_d = StFault;
                    code_d  = CodeTimeout;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StFault: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // An external load (trap/RTI) wins over a commit on the same edge.
    always_comb begin
        ps_d = ps_q;
        if (ps_ld) begin
            ps_d = ps_ld_val;
        end else if (commit && ps_we_q) begin
            ps_d = ps_new_q;
        end
    end

    always_comb begin
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        rf_wbyte  = 1'b0;
        bus_req   = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_sel   = '0;
        wb_err    = 1'b0;
        unique case (state_q)
            StCommit: begin
                if (dest_q == DestReg) begin
                    rf_we    = 1'b1;
                    rf_waddr = reg_q;
                    if (byte_q && sxt_q) begin
                        rf_wdata = {{8{d_q[7]}}, d_q[7:0]};
                    end else begin
                        rf_wdata = d_q;
                        rf_wbyte = byte_q;
                    end
                end
            end
            StBus: begin
                bus_req  = 1'b1;
                bus_addr = {addr_q[15:1], 1'b0};
                if (byte_q) begin
                    bus_wdata = {d_q[7:0], d_q[7:0]};
                    bus_sel   = addr_q[0] ? 2'b10 : 2'b01;
                end else begin
                    bus_wdata = d_q;
                    bus_sel   = 2'b11;
                end
            end
            StFault: wb_err = 1'b1;
            default: ;
        endcase
    end

    assign ps          = ps_q;
    assign wb_err_code = code_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Scenario bench for alu_writeback: expected write-back events are queued when a transaction is
// driven and popped when the stage produces its register, bus or fault output.
module tb_alu_writeback;

    localparam int unsigned Timeout = 4;
    localparam logic [7:0]  PsInit  = 8'hE0;

    localparam int KRf   = 0;
    localparam int KBus  = 1;
    localparam int KErr  = 2;
    localparam int KNone = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [15:0] in_d;
    logic [7:0]  in_ps;
    logic        in_ps_we;
    logic [1:0]  in_dest;
    logic [2:0]  in_reg;
    logic [15:0] in_addr;
    logic        in_byte, in_sxt;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        rf_wbyte;
    logic        bus_req;
    logic [15:0] bus_addr, bus_wdata;
    logic [1:0]  bus_sel;
    logic        bus_ack, bus_err;
    logic        ps_ld;
    logic [7:0]  ps_ld_val, ps;
    logic        wb_err;
    logic [1:0]  wb_err_code;

    typedef struct {
        int          kind;
        logic [2:0]  waddr;
        logic [15:0] data;
        logic        wbyte;
        logic [15:0] addr;
        logic [1:0]  sel;
        logic [1:0]  code;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    alu_writeback #(
        .TIMEOUT (Timeout),
        .PS_INIT (PsInit)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_d        (in_d),
        .in_ps       (in_ps),
        .in_ps_we    (in_ps_we),
        .in_dest     (in_dest),
        .in_reg      (in_reg),
        .in_addr     (in_addr),
        .in_byte     (in_byte),
        .in_sxt      (in_sxt),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .rf_wbyte    (rf_wbyte),
        .bus_req     (bus_req),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_sel     (bus_sel),
        .bus_ack     (bus_ack),
        .bus_err     (bus_err),
        .ps_ld       (ps_ld),
        .ps_ld_val   (ps_ld_val),
        .ps          (ps),
        .wb_err      (wb_err),
        .wb_err_code (wb_err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t make_exp(input int kind, input logic [2:0] waddr,
                                      input logic [15:0] data, input logic wbyte,
                                      input logic [15:0] addr, input logic [1:0] sel,
                                      input logic [1:0] code);
        exp_t e;
        e.kind  = kind;
        e.waddr = waddr;
        e.data  = data;
        e.wbyte = wbyte;
        e.addr  = addr;
        e.sel   = sel;
        e.code  = code;
        return e;
    endfunction

    function automatic int obs_kind();
        if (rf_we) return KRf;
        if (bus_req) return KBus;
        if (wb_err) return KErr;
        return KNone;
    endfunction

    // Returns just after the accepting edge.
    task automatic drive_txn(input logic [1:0] dest, input logic [2:0] rg,
                             input logic [15:0] addr, input logic [15:0] d,
                             input logic [7:0] psv, input logic we, input logic byt,
                             input logic sxt);
        int n = 0;
        @(posedge clk);
        #1;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        in_dest  = dest;
        in_reg   = rg;
        in_addr  = addr;
        in_d     = d;
        in_ps    = psv;
        in_ps_we = we;
        in_byte  = byt;
        in_sxt   = sxt;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Leaves the bench at the negedge of the first cycle showing any output activity.
    task automatic wait_out(output bit timed_out);
        int n = 0;
        @(negedge clk);
        while (!(rf_we || bus_req || wb_err) && n < 20) begin
            @(negedge clk);
            n++;
        end
        timed_out = (n >= 20);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++; if (ps !== PsInit) $display("FAIL reset_ps: got %h want %h", ps, PsInit); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else pass_cnt++;
        total_cnt++;
        if ({rf_we, rf_waddr, rf_wdata, rf_wbyte} !== '0)
            $display("FAIL reset_rf: got %b/%h/%h/%b want 0", rf_we, rf_waddr, rf_wdata, rf_wbyte);
        else pass_cnt++;
        total_cnt++;
        if ({bus_req, bus_addr, bus_wdata, bus_sel} !== '0)
            $display("FAIL reset_bus: got %b/%h/%h/%b want 0", bus_req, bus_addr, bus_wdata, bus_sel);
        else pass_cnt++;
        total_cnt++;
        if ({wb_err, wb_err_code} !== 3'b000)
            $display("FAIL reset_err: got %b/%0d want 0/0", wb_err, wb_err_code);
        else pass_cnt++;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reg_word();
        exp_t e;
        bit   to;
        exp_q.push_back(make_exp(KRf, 3'd3, 16'h1234, 1'b0, 16'h0, 2'b00, 2'd0));
        drive_txn(2'd1, 3'd3, 16'h0, 16'h1234, 8'h04, 1'b1, 1'b0, 1'b0);
        wait_out(to);
        e = exp_q.pop_front();
        total_cnt++; if (to) $display("FAIL regw_timeout: got no output want rf write"); else pass_cnt++;
        total_cnt++; if (obs_kind() !== e.kind) $display("FAIL regw_kind: got %0d want %0d", obs_kind(), e.kind); else pass_cnt++;
        total_cnt++; if (rf_waddr !== e.waddr) $display("FAIL regw_waddr: got %0d want %0d", rf_waddr, e.waddr); else pass_cnt++;
        total_cnt++; if (rf_wdata !== e.data) $display("FAIL regw_wdata: got %h want %h", rf_wdata, e.data); else pass_cnt++;
        total_cnt++; if (rf_wbyte !== e.wbyte) $display("FAIL regw_wbyte: got %b want %b", rf_wbyte, e.wbyte); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (rf_we !== 1'b0) $display("FAIL regw_pulse: got %b want 0", rf_we); else pass_cnt++;
        total_cnt++; if (ps !== 8'h04) $display("FAIL regw_ps: got %h want 04", ps); else pass_cnt++;
    endtask

    task automatic test_reg_byte();
        logic [15:0] d_tab[3];
        logic        sxt_tab[3];
        logic [15:0] wd_tab[3];
        logic        wb_tab[3];
        exp_t        e;
        bit          to;
        d_tab   = '{16'h55F0, 16'h5570, 16'h55F0};
        sxt_tab = '{1'b1, 1'b1, 1'b0};
        wd_tab  = '{16'hFFF0, 16'h0070, 16'h55F0};
        wb_tab  = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(make_exp(KRf, 3'd6, wd_tab[i], wb_tab[i], 16'h0, 2'b00, 2'd0));
            drive_txn(2'd1, 3'd6, 16'h0, d_tab[i], 8'hAA, 1'b0, 1'b1, sxt_tab[i]);
            wait_out(to);
            e = exp_q.pop_front();
            total_cnt++; if (obs_kind() !== e.kind) $display("FAIL regb%0d_kind: got %0d want %0d", i, obs_kind(), e.kind); else pass_cnt++;
            total_cnt++; if (rf_wdata !== e.data) $display("FAIL regb%0d_wdata: got %h want %h", i, rf_wdata, e.data); else pass_cnt++;
            total_cnt++; if (rf_wbyte !== e.wbyte) $display("FAIL regb%0d_wbyte: got %b want %b", i, rf_wbyte, e.wbyte); else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++; if (ps !== 8'h04) $display("FAIL regb_ps_kept: got %h want 04", ps); else pass_cnt++;
    endtask

    task automatic test_bus_byte_ack();
        exp_t e;
        bit   to;
        int   nreq = 0;
        exp_q.push_back(make_exp(KBus, 3'd0, 16'hABAB, 1'b0, 16'h1000, 2'b10, 2'd0));
        drive_txn(2'd2, 3'd0, 16'h1001, 16'h00AB, 8'h0F, 1'b1, 1'b1, 1'b0);
        wait_out(to);
        e = exp_q.pop_front();
        total_cnt++; if (obs_kind() !== e.kind) $display("FAIL busb_kind: got %0d want %0d", obs_kind(), e.kind); else pass_cnt++;
        total_cnt++; if (bus_addr !== e.addr) $display("FAIL busb_addr: got %h want %h", bus_addr, e.addr); else pass_cnt++;
        total_cnt++; if (bus_sel !== e.sel) $display("FAIL busb_sel: got %b want %b", bus_sel, e.sel); else pass_cnt++;
        total_cnt++; if (bus_wdata !== e.data) $display("FAIL busb_wdata: got %h want %h", bus_wdata, e.data); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL busb_ready: got %b want 0", in_ready); else pass_cnt++;
        repeat (2) begin
            @(negedge clk);
            if (bus_req) nreq++;
        end
        bus_ack = 1'b1;
        @(posedge clk);
        #1;
        bus_ack = 1'b0;
        @(negedge clk);
        total_cnt++; if (nreq !== 2) $display("FAIL busb_req_len: got %0d want 3 cycles", nreq + 1); else pass_cnt++;
        total_cnt++; if (bus_req !== 1'b0) $display("FAIL busb_req_drop: got %b want 0", bus_req); else pass_cnt++;
        total_cnt++; if (ps !== 8'h0F) $display("FAIL busb_ps: got %h want 0F", ps); else pass_cnt++;
    endtask

    task automatic test_bus_faults();
        exp_t e;
        bit   to;
        int   nreq = 0;
        exp_q.push_back(make_exp(KBus, 3'd0, 16'hBEEF, 1'b0, 16'h3000, 2'b11, 2'd0));
        exp_q.push_back(make_exp(KErr, 3'd0, 16'h0, 1'b0, 16'h0, 2'b00, 2'd2));
        drive_txn(2'd2, 3'd0, 16'h3000, 16'hBEEF, 8'h77, 1'b1, 1'b0, 1'b0);
        wait_out(to);
        e = exp_q.pop_front();
        total_cnt++; if (bus_sel !== e.sel) $display("FAIL busw_sel: got %b want %b", bus_sel, e.sel); else pass_cnt++;
        total_cnt++; if (bus_wdata !== e.data) $display("FAIL busw_wdata: got %h want %h", bus_wdata, e.data); else pass_cnt++;
        while (bus_req && nreq < 20) begin
            nreq++;
            @(negedge clk);
        end
        e = exp_q.pop_front();
        total_cnt++; if (nreq !== Timeout) $display("FAIL tmo_req_len: got %0d want %0d", nreq, Timeout); else pass_cnt++;
        total_cnt++; if (obs_kind() !== e.kind) $display("FAIL tmo_kind: got %0d want %0d", obs_kind(), e.kind); else pass_cnt++;
        total_cnt++; if (wb_err_code !== e.code) $display("FAIL tmo_code: got %0d want %0d", wb_err_code, e.code); else pass_cnt++;
        total_cnt++; if (ps !== 8'h0F) $display("FAIL tmo_ps: got %h want 0F", ps); else pass_cnt++;

        exp_q.push_back(make_exp(KErr, 3'd0, 16'h0, 1'b0, 16'h0, 2'b00, 2'd1));
        drive_txn(2'd2, 3'd0, 16'h4000, 16'h0001, 8'h88, 1'b1, 1'b0, 1'b0);
        wait_out(to);
        bus_err = 1'b1;
        bus_ack = 1'b1;
        @(posedge clk);
        #1;
        bus_err = 1'b0;
        bus_ack = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        total_cnt++; if (obs_kind() !== e.kind) $display("FAIL berr_kind: got %0d want %0d", obs_kind(), e.kind); else pass_cnt++;
        total_cnt++; if (wb_err_code !== e.code) $display("FAIL berr_code: got %0d want %0d", wb_err_code, e.code); else pass_cnt++;
        total_cnt++; if (ps !== 8'h0F) $display("FAIL berr_ps: got %h want 0F", ps); else pass_cnt++;
    endtask

    task automatic test_odd_addr();
        exp_t e;
        bit   to;
        exp_q.push_back(make_exp(KErr, 3'd0, 16'h0, 1'b0, 16'h0, 2'b00, 2'd0));
        drive_txn(2'd2, 3'd0, 16'h2001, 16'h1234, 8'h33, 1'b1, 1'b0, 1'b0);
        wait_out(to);
        e = exp_q.pop_front();
        total_cnt++; if (obs_kind() !== e.kind) $display("FAIL odd_kind: got %0d want %0d", obs_kind(), e.kind); else pass_cnt++;
        total_cnt++; if (wb_err_code !== e.code) $display("FAIL odd_code: got %0d want %0d", wb_err_code, e.code); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (wb_err !== 1'b0) $display("FAIL odd_pulse: got %b want 0", wb_err); else pass_cnt++;
        total_cnt++; if (wb_err_code !== e.code) $display("FAIL odd_code_held: got %0d want %0d", wb_err_code, e.code); else pass_cnt++;
        total_cnt++; if (ps !== 8'h0F) $display("FAIL odd_ps: got %h want 0F", ps); else pass_cnt++;
    endtask

    task automatic test_ps_ld();
        exp_t e;
        bit   to;
        @(posedge clk);
        #1;
        ps_ld     = 1'b1;
        ps_ld_val = 8'h5A;
        @(posedge clk);
        #1;
        ps_ld = 1'b0;
        @(negedge clk);
        total_cnt++; if (ps !== 8'h5A) $display("FAIL psld_idle: got %h want 5A", ps); else pass_cnt++;

        exp_q.push_back(make_exp(KRf, 3'd5, 16'hCAFE, 1'b0, 16'h0, 2'b00, 2'd0));
        drive_txn(2'd1, 3'd5, 16'h0, 16'hCAFE, 8'h0F, 1'b1, 1'b0, 1'b0);
        wait_out(to);
        e = exp_q.pop_front();
        total_cnt++; if (rf_wdata !== e.data) $display("FAIL psld_wdata: got %h want %h", rf_wdata, e.data); else pass_cnt++;
        ps_ld     = 1'b1;
        ps_ld_val = 8'hE0;
        @(posedge clk);
        #1;
        ps_ld = 1'b0;
        @(negedge clk);
        total_cnt++; if (ps !== 8'hE0) $display("FAIL psld_override: got %h want E0", ps); else pass_cnt++;
    endtask

    task automatic test_reset_mid_bus();
        exp_t e;
        bit   to;
        @(posedge clk);
        #1;
        ps_ld     = 1'b1;
        ps_ld_val = 8'h3C;
        @(posedge clk);
        #1;
        ps_ld = 1'b0;
        exp_q.push_back(make_exp(KBus, 3'd0, 16'h1111, 1'b0, 16'h5000, 2'b11, 2'd0));
        drive_txn(2'd2, 3'd0, 16'h5000, 16'h1111, 8'h99, 1'b1, 1'b0, 1'b0);
        wait_out(to);
        e = exp_q.pop_front();
        total_cnt++; if (bus_addr !== e.addr) $display("FAIL rstbus_addr: got %h want %h", bus_addr, e.addr); else pass_cnt++;
        total_cnt++; if (ps !== 8'h3C) $display("FAIL rstbus_ps_pre: got %h want 3C", ps); else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++; if (bus_req !== 1'b0) $display("FAIL rstbus_req: got %b want 0", bus_req); else pass_cnt++;
        total_cnt++; if (ps !== PsInit) $display("FAIL rstbus_ps: got %h want %h", ps, PsInit); else pass_cnt++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        total_cnt++; if (bus_req !== 1'b0) $display("FAIL rstbus_lost: got %b want 0", bus_req); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rstbus_ready: got %b want 1", in_ready); else pass_cnt++;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_d      = '0;
        in_ps     = '0;
        in_ps_we  = 1'b0;
        in_dest   = '0;
        in_reg    = '0;
        in_addr   = '0;
        in_byte   = 1'b0;
        in_sxt    = 1'b0;
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        ps_ld     = 1'b0;
        ps_ld_val = '0;

        test_reset();
        test_reg_word();
        test_reg_byte();
        test_bus_byte_ack();
        test_bus_faults();
        test_odd_addr();
        test_ps_ld();
        test_reset_mid_bus();

        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        else pass_cnt++;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
